// File: rtl/lifo_pkg.sv
// Shared types and width helpers for the hardware LIFO stack.
package lifo_pkg;

  // Per-edge operation resolved from CLR/PUSH/POP and the current fill state.
  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_CLEAR
  } lifo_op_t;

  // COUNT must represent 0..depth inclusive.
  function automatic int lifo_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Storage index width; never below one bit.
  function automatic int lifo_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lifo_ram.sv
// Depth x DataWidth stack storage: one synchronous write port, one
// combinational read port, no reset so FPGA tools can map it to distributed RAM.
module lifo_ram
  import lifo_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = 16,
  parameter int AddrWidth = lifo_addr_width(Depth)
) (
  input  logic                 CLK,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem_q [Depth];

  // Write port: one entry per edge when enabled.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack. The top entry lives in a dedicated register (DTO);
// the array is read combinationally at COUNT-2 so the entry below the top is
// always ready, which lets a pop land every cycle without bubbles.
module lifo_stack
  import lifo_pkg::*;
#(
  parameter  int DataWidth = 32,
  parameter  int Depth     = 16,
  localparam int CntWidth  = lifo_cnt_width(Depth)
) (
  input  logic                 RESET,
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 PUSH,
  input  logic                 POP,
  input  logic [DataWidth-1:0] DTI,
  output logic [DataWidth-1:0] DTO,
  output logic [CntWidth-1:0]  COUNT,
  output logic                 EMPTY,
  output logic                 FULL,
  output logic                 OVF,
  output logic                 UNF
);

  localparam int AddrWidth = lifo_addr_width(Depth);
  localparam logic [CntWidth-1:0] CntZero = '0;
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
  localparam logic [CntWidth-1:0] CntTwo  = CntWidth'(2);
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(Depth);

  logic [CntWidth-1:0]  count_q, count_d;
  logic [DataWidth-1:0] top_q, top_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  logic                 is_empty;
  logic                 is_full;
  lifo_op_t             op;

  logic                 ram_we;
  logic [AddrWidth-1:0] ram_waddr;
  logic [AddrWidth-1:0] ram_raddr;
  logic [DataWidth-1:0] ram_rdata;

  assign is_empty = (count_q == CntZero);
  assign is_full  = (count_q == CntFull);

  // Resolve the request into one operation; push+pop on an empty stack is a plain push.
  always_comb begin
    op = OP_NONE;
    if (CLR) begin
      op = OP_CLEAR;
    end else if (PUSH && POP) begin
      op = is_empty ? OP_PUSH : OP_REPLACE;
    end else if (PUSH) begin
      op = OP_PUSH;
    end else if (POP) begin
      op = OP_POP;
    end
  end

  // Next-below entry: only meaningful with two or more entries, otherwise index 0.
  assign ram_raddr = (count_q >= CntTwo) ? AddrWidth'(count_q - CntTwo) : '0;

  // Next-state and storage write control for the selected operation.
  always_comb begin
    count_d   = count_q;
    top_d     = top_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ram_we    = 1'b0;
    ram_waddr = '0;
    unique case (op)
      OP_CLEAR: begin
        count_d = CntZero;
        top_d   = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
      end
      OP_PUSH: begin
        if (is_full) begin
          // Data is dropped; only the sticky flag records the attempt.
          ovf_d = 1'b1;
        end else begin
          ram_we    = 1'b1;
          ram_waddr = AddrWidth'(count_q);
          count_d   = count_q + CntOne;
          top_d     = DTI;
        end
      end
      OP_POP: begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else begin
          count_d = count_q - CntOne;
          // Popping the last entry must show 0, never stale array contents.
          top_d   = (count_q == CntOne) ? '0 : ram_rdata;
        end
      end
      OP_REPLACE: begin
        // Array copy of the top is rewritten too, so a later pop-through sees it.
        ram_we    = 1'b1;
        ram_waddr = AddrWidth'(count_q - CntOne);
        top_d     = DTI;
      end
      default: begin
      end
    endcase
  end

  // Stack state registers; an asynchronous reset discards any in-flight push.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_q <= CntZero;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  lifo_ram #(
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .AddrWidth (AddrWidth)
  ) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (DTI),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign DTO   = top_q;
  assign COUNT = count_q;
  assign EMPTY = is_empty;
  assign FULL  = is_full;
  assign OVF   = ovf_q;
  assign UNF   = unf_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack (default 32 x 16).
module tb_lifo_stack;
  import lifo_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          RESET, CLK, CLR, PUSH, POP;
  logic [DW-1:0] DTI, DTO;
  logic [CW-1:0] COUNT;
  logic          EMPTY, FULL, OVF, UNF;

  lifo_stack #(.DataWidth(DW), .Depth(DEPTH)) dut (
    .RESET (RESET), .CLK (CLK), .CLR (CLR), .PUSH (PUSH), .POP (POP),
    .DTI (DTI), .DTO (DTO), .COUNT (COUNT), .EMPTY (EMPTY), .FULL (FULL),
    .OVF (OVF), .UNF (UNF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] dto;
    logic [CW-1:0] cnt;
    logic          empty, full, ovf, unf;
  } exp_t;

  typedef struct {
    logic          clr, push, pop;
    logic [DW-1:0] dti;
    exp_t          e;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  // reference model: a plain queue as the stack
  logic [DW-1:0] m_stk[$];
  logic          m_ovf, m_unf;

  function automatic lifo_op_t decode_op(input logic c, p, o, input int size);
    if (c) return OP_CLEAR;
    if (p && o) return (size == 0) ? OP_PUSH : OP_REPLACE;
    if (p) return OP_PUSH;
    if (o) return OP_POP;
    return OP_NONE;
  endfunction

  task automatic model_step(input logic c, p, o, input logic [DW-1:0] d);
    case (decode_op(c, p, o, m_stk.size()))
      OP_CLEAR:   begin m_stk.delete(); m_ovf = 0; m_unf = 0; end
      OP_PUSH:    if (m_stk.size() == DEPTH) m_ovf = 1; else m_stk.push_back(d);
      OP_POP:     if (m_stk.size() == 0) m_unf = 1; else void'(m_stk.pop_back());
      OP_REPLACE: m_stk[m_stk.size()-1] = d;
      default:    ;
    endcase
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.dto   = (m_stk.size() == 0) ? '0 : m_stk[m_stk.size()-1];
    e.cnt   = CW'(m_stk.size());
    e.empty = (m_stk.size() == 0);
    e.full  = (m_stk.size() == DEPTH);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  function automatic vec_t mk(input logic c, p, o, input logic [DW-1:0] d,
                              input logic [DW-1:0] dto, input int cnt,
                              input logic em, fu, ov, un);
    vec_t v;
    v.clr = c; v.push = p; v.pop = o; v.dti = d;
    v.e.dto = dto; v.e.cnt = CW'(cnt); v.e.empty = em; v.e.full = fu;
    v.e.ovf = ov; v.e.unf = un;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty, got none want entry", tag);
      return;
    end
    e = exp_q.pop_front();
    cmp({tag, ".dto"},   DTO,         e.dto);
    cmp({tag, ".count"}, DW'(COUNT),  DW'(e.cnt));
    cmp({tag, ".empty"}, DW'(EMPTY),  DW'(e.empty));
    cmp({tag, ".full"},  DW'(FULL),   DW'(e.full));
    cmp({tag, ".ovf"},   DW'(OVF),    DW'(e.ovf));
    cmp({tag, ".unf"},   DW'(UNF),    DW'(e.unf));
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input logic c, p, o, input logic [DW-1:0] d, input exp_t e,
                      input string tag);
    @(negedge CLK);
    CLR = c; PUSH = p; POP = o; DTI = d;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    check_out(tag);
  endtask

  task automatic mstep(input logic c, p, o, input logic [DW-1:0] d, input string tag);
    model_step(c, p, o, d);
    step(c, p, o, d, model_exp(), tag);
  endtask

  vec_t vecs[16];

  initial begin
    RESET = 1'b0; CLR = 0; PUSH = 0; POP = 0; DTI = '0;
    m_ovf = 0; m_unf = 0;

    // directed vectors: {clr,push,pop,dti} -> {dto,count,empty,full,ovf,unf}
    vecs[0]  = mk(0,1,0,32'h11, 32'h11,1, 0,0,0,0);
    vecs[1]  = mk(0,1,0,32'h22, 32'h22,2, 0,0,0,0);
    vecs[2]  = mk(0,1,0,32'h33, 32'h33,3, 0,0,0,0);
    vecs[3]  = mk(0,0,1,32'h0,  32'h22,2, 0,0,0,0);
    vecs[4]  = mk(0,0,1,32'h0,  32'h11,1, 0,0,0,0);
    vecs[5]  = mk(0,0,1,32'h0,  32'h0, 0, 1,0,0,0);
    vecs[6]  = mk(0,0,1,32'h0,  32'h0, 0, 1,0,0,1);
    vecs[7]  = mk(1,1,1,32'hEE, 32'h0, 0, 1,0,0,0);
    vecs[8]  = mk(0,1,0,32'h5,  32'h5, 1, 0,0,0,0);
    vecs[9]  = mk(0,1,0,32'h6,  32'h6, 2, 0,0,0,0);
    vecs[10] = mk(0,1,1,32'h9,  32'h9, 2, 0,0,0,0);
    vecs[11] = mk(0,0,1,32'h0,  32'h5, 1, 0,0,0,0);
    vecs[12] = mk(0,0,1,32'h0,  32'h0, 0, 1,0,0,0);
    vecs[13] = mk(0,1,1,32'h7,  32'h7, 1, 0,0,0,0);
    vecs[14] = mk(0,0,1,32'h0,  32'h0, 0, 1,0,0,0);
    vecs[15] = mk(0,0,0,32'hAB, 32'h0, 0, 1,0,0,0);

    // reset state while RESET is held low
    repeat (2) @(posedge CLK);
    #1;
    exp_q.push_back(model_exp());
    check_out("reset");
    @(negedge CLK);
    RESET = 1'b1;

    foreach (vecs[i]) begin
      model_step(vecs[i].clr, vecs[i].push, vecs[i].pop, vecs[i].dti);
      step(vecs[i].clr, vecs[i].push, vecs[i].pop, vecs[i].dti, vecs[i].e,
           $sformatf("vec%0d", i));
    end

    // fill to full, replace on full, overflow, drain past empty
    for (int i = 0; i < DEPTH; i++) mstep(0, 1, 0, DW'(i), $sformatf("fill%0d", i));
    mstep(0, 1, 1, 32'hCC, "replace_full");
    mstep(0, 1, 1, 32'hF,  "replace_back");
    mstep(0, 1, 0, 32'hAA, "overflow");
    for (int i = 0; i < DEPTH; i++) mstep(0, 0, 1, '0, $sformatf("drain%0d", i));
    mstep(0, 0, 1, '0, "underflow");
    mstep(1, 0, 0, '0, "clear_flags");

    // asynchronous reset in the middle of a cycle with PUSH pending
    for (int i = 0; i < 3; i++) mstep(0, 1, 0, DW'(32'h100 + i), $sformatf("pre_rst%0d", i));
    @(negedge CLK);
    PUSH = 1; POP = 0; CLR = 0; DTI = 32'hDEAD;
    #2;
    RESET = 1'b0;
    #1;
    m_stk.delete(); m_ovf = 0; m_unf = 0;
    exp_q.push_back(model_exp());
    check_out("async_rst");
    @(posedge CLK);
    #1;
    exp_q.push_back(model_exp());
    check_out("rst_held");
    @(negedge CLK);
    PUSH = 0;
    RESET = 1'b1;
    mstep(0, 0, 1, '0, "pop_after_rst");
    mstep(1, 0, 0, '0, "clear_after_rst");

    // random mix against the model
    for (int i = 0; i < 300; i++) begin
      logic c, p, o;
      c = ($urandom_range(0, 99) < 3);
      p = ($urandom_range(0, 99) < 55);
      o = ($urandom_range(0, 99) < 45);
      mstep(c, p, o, $urandom(), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Parametrised hardware stack (LIFO) for core-internal return-address, operand and context stacks.
- Generalised in width and depth.
- Adds full/empty/occupancy status, sticky overflow/underflow error flags, a synchronous clear, and a defined simultaneous push+pop (replace-top) mode.
- DTO always presents the current top-of-stack, registered.

Parameters:
- DataWidth, 32, bit width of each stack entry.
- Depth, 16, number of entries; any value >= 2, not required to be a power of 2.
- CntWidth, $clog2(Depth+1), width of COUNT; derived, not overridden.

Ports:
- RESET  input  1  asynchronous, active-low reset
- CLK  input  1  clock, all state on rising edge
- CLR  input  1  synchronous clear: empties stack, clears error flags
- PUSH  input  1  push DTI onto stack
- POP  input  1  remove top entry
- DTI  input  DataWidth  push/replace data
- DTO  output  DataWidth  current top-of-stack, registered; 0 when empty
- COUNT  output  CntWidth  number of valid entries, 0..Depth
- EMPTY  output  1  COUNT==0
- FULL  output  1  COUNT==Depth
- OVF  output  1  sticky: push attempted while full
- UNF  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (RESET low, asynchronous): COUNT=0, DTO=0, EMPTY=1, FULL=0, OVF=0, UNF=0. Storage array contents are not reset and undefined.
- All outputs are registered. EMPTY and FULL are decoded from registered state with no extra latency vs COUNT.
- Operation decode, evaluated per edge in priority order:
  - CLR=1: COUNT<=0, DTO<=0, OVF<=0, UNF<=0. PUSH and POP are ignored that cycle.
  - PUSH=1, POP=0, not full: entry stored at position COUNT, COUNT<=COUNT+1, DTO<=DTI (visible the cycle after the edge).
  - PUSH=1, POP=0, full: no state change except OVF<=1. DTO and COUNT are unchanged. The data is dropped.
  - PUSH=0, POP=1, not empty: COUNT<=COUNT-1. DTO<=entry at position COUNT-2, or 0 if COUNT was 1.
  - PUSH=0, POP=1, empty: no change except UNF<=1.
  - PUSH=1, POP=1, not empty (including full): replace-top. Top entry overwritten with DTI, DTO<=DTI, COUNT unchanged. No flag set.
  - PUSH=1, POP=1, empty: treated as plain push. COUNT<=1, DTO<=DTI, UNF unchanged.
  - Neither asserted: hold.
- Latency:
  - Back-to-back pops must each present the correct new top one cycle after their edge, with no bubbles.
  - A pop directly after a push must return the previously pushed entries in exact LIFO order.
  - Implementation holds the top entry in a register and prefetches the next-below entry so that sustained POP every cycle works.
- OVF and UNF stay set until CLR or RESET. They do not block further operations.
- Reset mid-operation: any in-flight push is discarded. After reset release the stack is empty and the stale array contents must never appear on DTO.
- Wrap-around: none. The pointer saturates logically at 0 and Depth via the guard conditions above. It never wraps.

Decomposition:
- Package lifo_pkg:
  - enum lifo_op_t {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE, OP_CLEAR}, used by the decode logic and the bench scoreboard.
  - function lifo_cnt_width(depth).
- Sub-module lifo_ram: Depth x DataWidth storage array. One synchronous write port, one combinational read port, no reset. Kept separate so FPGA targets can infer distributed RAM.

Test Plan:
- Push 0x11,0x22,0x33 on consecutive cycles -> DTO 0x11,0x22,0x33 one cycle after each edge, COUNT=3. Then POP x3 back-to-back -> DTO 0x22,0x11,0, EMPTY=1, UNF=0.
- Depth=16: push 0..15 -> FULL=1, COUNT=16. Push 0xAA -> OVF=1, DTO=15, COUNT=16. Pop 16 times -> values 14..0 then 0, EMPTY=1.
- Empty stack, POP -> UNF=1, COUNT=0, DTO=0. Then CLR -> UNF=0, OVF=0.
- Stack holds 0x5,0x6. PUSH+POP with DTI=0x9 -> DTO=0x9, COUNT=2. POP -> DTO=0x5.
- Empty stack, PUSH+POP with DTI=0x7 -> COUNT=1, DTO=0x7, UNF=0. Full stack, PUSH+POP -> top replaced, OVF=0.
- Push 3 entries, assert RESET low mid-cycle with PUSH high -> immediately COUNT=0, DTO=0, EMPTY=1. After release, POP sets UNF=1.
